tl_timer: RTL
=============

# tl_timer

Interval timer serving the highway/farm traffic-light controller: it consumes the controller's registered start-timer pulse (`st`) and returns the short-interval (`ts`) and long-interval (`tl`) expiry flags that drive yellow-phase and green-phase transitions. It sits beside the controller on the same clock. It is the timing half of the controller's `ST`/`ts`/`tl` handshake.

## Interface
- `PRESCALE`, default 50: clock cycles per timer tick; legal range ≥1.
- `SHORT_TICKS`, default 3: ticks until `ts` asserts; legal range ≥1.
- `LONG_TICKS`, default 10: ticks until `tl` asserts; must be > `SHORT_TICKS`.
- `CNT_W`, default 8: tick-counter width; must satisfy `LONG_TICKS` < 2^`CNT_W`.
- `clk`  input  1  sole clock; rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `st`  input  1  restart request, sampled on each rising edge; one-cycle pulse from the controller; held high acts as a continuous restart.
- `ts`  output  1  short interval elapsed; level.
- `tl`  output  1  long interval elapsed; level.
- `hold`  input  1  pause counting; present only with `TL_TIMER_HOLD_EN`.

## Operation
- FSM states:
  - `T_SHORT`: counting; `ts`=0, `tl`=0.
  - `T_LONG`: counting; `ts`=1, `tl`=0.
  - `T_DONE`: counter frozen; `ts`=1, `tl`=1.
- `ts` and `tl` are decoded from the state register only; they never depend combinationally on `st`.
- Prescaler `pre_cnt` runs 0..`PRESCALE`-1. `tick` is asserted when `pre_cnt`==`PRESCALE`-1 at an edge; at that edge `pre_cnt` wraps to 0.
- Tick counter `tcnt` increments on `tick`.
- `T_SHORT`→`T_LONG` when `tcnt` becomes `SHORT_TICKS`. `T_LONG`→`T_DONE` when `tcnt` becomes `LONG_TICKS`.
- In `T_DONE`, `tcnt` and `pre_cnt` stop. Flags stay high indefinitely until the next `st`; no wrap-around.
- `st`=1 at an edge, from any state: `pre_cnt`←0, `tcnt`←0, state←`T_SHORT`. A restart in the same cycle as a tick or state change wins.
- Reset (async, any time, including mid-interval): state `T_SHORT`, `pre_cnt`=0, `tcnt`=0, `ts`=0, `tl`=0.
- Counting begins on the first edge after `reset_n` rises, so release from reset behaves as an implicit `st`. This is mandatory: the controller leaves its initial state only on `tl`, and it issues no start pulse out of reset.

## Timing
- With `st` sampled at edge k (or reset released before edge k+1):
  - `ts` rises after edge k + `SHORT_TICKS`×`PRESCALE`.
  - `tl` rises after edge k + `LONG_TICKS`×`PRESCALE`.
- With `PRESCALE`=1, a tick occurs every cycle.
- Flags drop after the edge that samples `st`, which is one cycle of latency. The controller's registered `ST_o` arrives one cycle after its state change, so the flag that caused the transition is visible for at most one extra cycle. The controller ignores it in the new state.
- Back-to-back `st` pulses each restart the full interval; no minimum spacing.

## Configuration
- `TL_TIMER_HOLD_EN` defined: adds the `hold` input.
  - `hold`=1 freezes `pre_cnt`, `tcnt`, and state; flags keep their current values.
  - `st` overrides `hold` and still restarts.
  - Tick/expiry timing is extended by exactly the number of held cycles.
- Undefined: no `hold` port; the timer always counts.

## Structure
- Package `tl_timer_pkg`:
  - typedef of the state enum (`T_SHORT`, `T_LONG`, `T_DONE`).
  - default constants for `PRESCALE`, `SHORT_TICKS`, `LONG_TICKS`.
  - `TL_TIMER_HOLD_EN` gating.
- Sub-module `tl_prescaler`: holds `pre_cnt` and emits `tick`. Inputs are `clk`, `reset_n`, clear (`st`), and enable (~`hold` when configured).
- Top level holds `tcnt`, the FSM, and flag decode.
- Elaboration-time checks: reject `PRESCALE`<1, `SHORT_TICKS`<1, `LONG_TICKS`≤`SHORT_TICKS`, and a `CNT_W` overflow.

## Test plan
- Reset release, `PRESCALE`=4, `SHORT_TICKS`=3, `LONG_TICKS`=10, `st` low → `ts` high after 12 edges, `tl` high after 40 edges; both then stay high for 100+ cycles.
- Reset asserted at cycle 20 of an interval, released → `ts`/`tl` low immediately; `ts` at 12 cycles and `tl` at 40 cycles measured from the release edge.
- `st` pulse at cycle 25 (`ts`=1, `tl`=0) → `ts` drops after the next edge; `ts` re-asserts 12 cycles after the `st` edge.
- `st` in the cycle where `tcnt` would reach 10 → `tl` never asserts; restart wins.
- `st` held high 5 cycles → flags low throughout; `ts` asserts 12 cycles after the last high sample.
- With `TL_TIMER_HOLD_EN`: `hold` high for 7 cycles during `T_SHORT` → `ts` at 19 cycles; `hold` with `st` → restart occurs.

Source files
------------

// File: rtl/tl_timer_pkg.sv
// tl_timer_pkg: shared types and defaults for the traffic-light interval timer.
// Optional feature macro: TL_TIMER_HOLD_EN (adds the hold/pause input).
package tl_timer_pkg;

  // FSM encoding; the top-level compares against these values directly.
  typedef enum logic [1:0] {
    T_SHORT = 2'd0,
    T_LONG  = 2'd1,
    T_DONE  = 2'd2
  } tl_state_e;

  localparam int DEF_PRESCALE    = 50;
  localparam int DEF_SHORT_TICKS = 3;
  localparam int DEF_LONG_TICKS  = 10;
  localparam int DEF_CNT_W       = 8;

`ifdef TL_TIMER_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

endpackage

// File: rtl/tl_timer_if.sv
// tl_timer_if: start/flag handshake between the traffic-light controller and
// its interval timer. With TL_TIMER_HOLD_EN defined a hold (pause) line is added.
interface tl_timer_if;
  logic st;
  logic ts;
  logic tl;
`ifdef TL_TIMER_HOLD_EN
  logic hold;

  modport master (output st, output hold, input ts, input tl);
  modport slave  (input st, input hold, output ts, output tl);
`else
  modport master (output st, input ts, input tl);
  modport slave  (input st, output ts, output tl);
`endif
endinterface

// File: rtl/tl_prescaler.sv
// tl_prescaler: divides clk down to a one-cycle tick every PRESCALE enabled
// cycles. clr restarts the division and takes priority over en.
module tl_prescaler
  import tl_timer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // A one-bit counter is kept for PRESCALE==1; it simply stays at zero.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;

  assign tick = en & (pre_cnt == PRE_LAST);

  // Prescale counter: cleared by restart, wraps after PRE_LAST, frozen when disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= {PRE_W{1'b0}};
    end else if (clr) begin
      pre_cnt <= {PRE_W{1'b0}};
    end else if (en) begin
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= {PRE_W{1'b0}};
      end else begin
        pre_cnt <= pre_cnt + {{(PRE_W-1){1'b0}}, 1'b1};
      end
    end else begin
      pre_cnt <= pre_cnt;
    end
  end

endmodule

// File: rtl/tl_timer.sv
// tl_timer: short/long interval timer for the highway/farm traffic-light
// controller. st restarts both intervals; ts/tl are level flags decoded from
// the FSM state register. Leaving reset behaves like a start pulse.
// Optional feature macro: TL_TIMER_HOLD_EN (hold pauses all counting).
module tl_timer
  import tl_timer_pkg::*;
#(
  parameter int PRESCALE    = DEF_PRESCALE,
  parameter int SHORT_TICKS = DEF_SHORT_TICKS,
  parameter int LONG_TICKS  = DEF_LONG_TICKS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic       clk,
  input logic       reset_n,
  tl_timer_if.slave tif
);

  localparam logic [1:0] S_SHORT = T_SHORT;
  localparam logic [1:0] S_LONG  = T_LONG;
  localparam logic [1:0] S_DONE  = T_DONE;

  localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(SHORT_TICKS);
  localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Parameter sanity: refuse configurations that cannot produce both flags.
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("tl_timer: PRESCALE must be >= 1");
  end
  if (SHORT_TICKS < 1) begin : g_bad_short
    $error("tl_timer: SHORT_TICKS must be >= 1");
  end
  if (LONG_TICKS <= SHORT_TICKS) begin : g_bad_long
    $error("tl_timer: LONG_TICKS must exceed SHORT_TICKS");
  end
  if ((CNT_W < 31) && (LONG_TICKS >= (1 << CNT_W))) begin : g_bad_cnt_w
    $error("tl_timer: CNT_W too narrow for LONG_TICKS");
  end

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] tcnt;
  logic [CNT_W-1:0] tcnt_next;
  logic [CNT_W-1:0] tcnt_inc;
  logic             run;
  logic             pre_en;
  logic             tick;

`ifdef TL_TIMER_HOLD_EN
  assign run = ~tif.hold;
`else
  assign run = 1'b1;
`endif

  // Once both intervals have elapsed the prescaler is parked until the next st.
  assign pre_en   = run & (state != S_DONE);
  assign tcnt_inc = tcnt + CNT_ONE;

  tl_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tif.st),
    .en      (pre_en),
    .tick    (tick)
  );

  // Next-state and tick-count logic; a restart outranks any tick in the same cycle.
  always_comb begin
    state_next = state;
    tcnt_next  = tcnt;
    if (tif.st) begin
      state_next = S_SHORT;
      tcnt_next  = {CNT_W{1'b0}};
    end else if (tick) begin
      case (state)
        S_SHORT: begin
          tcnt_next = tcnt_inc;
          if (tcnt_inc == CNT_SHORT) begin
            state_next = S_LONG;
          end else begin
            state_next = S_SHORT;
          end
        end
        S_LONG: begin
          tcnt_next = tcnt_inc;
          if (tcnt_inc == CNT_LONG) begin
            state_next = S_DONE;
          end else begin
            state_next = S_LONG;
          end
        end
        S_DONE: begin
          state_next = S_DONE;
          tcnt_next  = tcnt;
        end
        default: begin
          state_next = S_SHORT;
          tcnt_next  = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_next = state;
      tcnt_next  = tcnt;
    end
  end

  // State and tick counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_SHORT;
      tcnt  <= {CNT_W{1'b0}};
    end else begin
      state <= state_next;
      tcnt  <= tcnt_next;
    end
  end

  // Flags come straight from the state register so st never reaches them combinationally.
  always_comb begin
    tif.ts = 1'b0;
    tif.tl = 1'b0;
    case (state)
      S_SHORT: begin
        tif.ts = 1'b0;
        tif.tl = 1'b0;
      end
      S_LONG: begin
        tif.ts = 1'b1;
        tif.tl = 1'b0;
      end
      S_DONE: begin
        tif.ts = 1'b1;
        tif.tl = 1'b1;
      end
      default: begin
        tif.ts = 1'b0;
        tif.tl = 1'b0;
      end
    endcase
  end

endmodule
